div_seq_controller: RTL and testbench
=====================================

// Module: div_seq_controller
// PURPOSE
//  Parametrised controller for the shift/subtract restoring divider datapath.
//  Successor to the fixed 8-bit controller: adds WIDTH-generic iteration count,
//  a start/valid/ack handshake with busy, divide-by-zero abort and a mid-run
//  restart policy. Drives the divisor/remainder register datapath and the
//  shared add/sub unit.
// PARAMETERS
//  WIDTH        8  divisor/quotient width in bits; iterations = WIDTH (2..32)
//  RESTART_EN   1  1: start while busy restarts at LOAD; 0: start ignored while busy
//  CW           $clog2(WIDTH+1)  iteration counter width (localparam, not overridable)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       request; sampled on clk in IDLE/DONE (and busy if RESTART_EN)
//  sign         in   1       sign of (Remainder[2W-1:W] - Divisor); 1 = negative
//  divisor_zero in   1       datapath divisor==0 flag, sampled with start
//  ack          in   1       consumer accepts result; releases DONE
//  load         out  1       load Divisor register
//  add          out  1       1 = add (restore), 0 = subtract
//  shift        out  1       shift Remainder left 1
//  inbit        out  1       bit shifted into Remainder[0]
//  sel          out  2       remainder mux: 10 dividend, 01 upper<=adder, 11 hold
//  valid        out  1       result (or dbz) available
//  busy         out  1       iteration in progress (LOAD/SUB/RESTORE/SHIFT1)
//  dbz          out  1       result invalid: divisor was zero
//  iter_cnt     out  CW      completed iterations (observability)
// BEHAVIOUR
//  - All outputs registered-state Moore decodes; no combinational path from inputs.
//  - Reset: state IDLE, iter_cnt 0, dbz 0; outputs load 0 add 0 shift 0 inbit 0
//    sel 11 valid 0 busy 0. Reset mid-run aborts immediately, no result.
//  - States / outputs (load,add,shift,inbit,sel,valid,busy):
//    IDLE    0,0,0,0,11,0,0
//    LOAD    1,0,1,0,10,0,1   ; clears iter_cnt
//    SUB     0,0,0,0,01,0,1
//    RESTORE 0,1,1,0,01,0,1   ; sign=1 path, quotient bit 0
//    SHIFT1  0,0,1,1,11,0,1   ; sign=0 path, quotient bit 1
//    DONE    0,0,0,0,11,1,0
//    Don't-care outputs are driven 0, never z.
//  - Transitions: IDLE --start&!divisor_zero--> LOAD; IDLE --start&divisor_zero-->
//    DONE with dbz<=1. LOAD->SUB. SUB->RESTORE if sign else SHIFT1.
//    RESTORE/SHIFT1: iter_cnt++; if iter_cnt==WIDTH-1 -> DONE else SUB.
//    DONE --ack--> IDLE (dbz<=0); DONE --start--> as IDLE (start wins over ack).
//  - Latency: start edge N -> LOAD at N+1 -> valid high from edge N+2+2*WIDTH
//    (WIDTH=8: 18 cycles). dbz path: valid at N+1.
//  - valid/dbz held stable in DONE until ack or start; ack outside DONE ignored.
//  - RESTART_EN=1: start in any busy state -> LOAD next cycle, iter_cnt cleared,
//    divisor_zero re-sampled. RESTART_EN=0: start while busy has no effect.
//  - iter_cnt saturates at WIDTH in DONE; never wraps.
// STRUCTURE
//  - Shared package div_pkg: state encodings (3-bit localparams), SEL_DIVIDEND=2'b10,
//    SEL_ADDER=2'b01, SEL_HOLD=2'b11, ADD/SUB opcode constants.
//  - One sub-module: div_iter_counter (CW-bit, clear/increment/terminal flag
//    at WIDTH-1). State register + next-state + output decode in top.
// TESTING
//  - WIDTH=8, dividend 100, divisor 7, model sign from reference datapath ->
//    quotient 14 rem 2; valid exactly 18 cycles after start; output table per state.
//  - divisor_zero=1 with start -> DONE next cycle, valid=1 dbz=1, load never pulsed;
//    ack -> IDLE, dbz=0.
//  - RESTART_EN=1, start re-asserted at iteration 5 -> LOAD next cycle, iter_cnt 0,
//    fresh 18-cycle latency; RESTART_EN=0 same stimulus -> original run completes.
//  - Async reset asserted mid-SUB (between edges) -> outputs at reset values
//    immediately; after release, start begins clean run.
//  - DONE held with ack=0 for 10 cycles -> valid stable; ack & start same cycle ->
//    LOAD taken, valid drops.
//  - WIDTH=16, 0xFFFF / 0x0003 -> 0x5555 rem 0; valid at 34 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings for the restoring-divider controller: state codes,
// remainder mux selects, adder opcodes and the per-state output decode.
package div_pkg;

    // State codes (3 bits, codes 6/7 unused and decode as IDLE)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SUB     = 3'd2;
    localparam logic [2:0] ST_RESTORE = 3'd3;
    localparam logic [2:0] ST_SHIFT1  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_SUB     = ST_SUB,
        S_RESTORE = ST_RESTORE,
        S_SHIFT1  = ST_SHIFT1,
        S_DONE    = ST_DONE
    } state_t;

    // Remainder register mux selects
    localparam logic [1:0] SEL_DIVIDEND = 2'b10;
    localparam logic [1:0] SEL_ADDER    = 2'b01;
    localparam logic [1:0] SEL_HOLD     = 2'b11;

    // Shared add/sub unit opcodes
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    // Control word driven towards the datapath
    typedef struct packed {
        logic       load;
        logic       add;
        logic       shift;
        logic       inbit;
        logic [1:0] sel;
        logic       valid;
        logic       busy;
    } ctrl_t;

    // Moore output decode; unused codes fall back to the IDLE row
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '{load: 1'b0, add: OP_SUB, shift: 1'b0, inbit: 1'b0,
              sel: SEL_HOLD, valid: 1'b0, busy: 1'b0};
        case (s)
            S_LOAD: begin
                c.load  = 1'b1;
                c.shift = 1'b1;
                c.sel   = SEL_DIVIDEND;
                c.busy  = 1'b1;
            end
            S_SUB: begin
                c.add  = OP_SUB;
                c.sel  = SEL_ADDER;
                c.busy = 1'b1;
            end
            S_RESTORE: begin
                c.add   = OP_ADD;
                c.shift = 1'b1;
                c.sel   = SEL_ADDER;
                c.busy  = 1'b1;
            end
            S_SHIFT1: begin
                c.shift = 1'b1;
                c.inbit = 1'b1;
                c.sel   = SEL_HOLD;
                c.busy  = 1'b1;
            end
            S_DONE: begin
                c.valid = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter: synchronous clear, increment that saturates at WIDTH,
// and a terminal flag raised while the count sits at WIDTH-1.
module div_iter_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_inc,
    output logic [CW-1:0] o_cnt,
    output logic          o_last
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    // Count completed iterations; clear has priority, never wraps past WIDTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_LAST);

endmodule

// File: rtl/div_seq_controller.sv
// Sequencing controller for a shift/subtract restoring divider.
// Handshake: start is accepted on a rising clk edge in IDLE or DONE (and in
// any busy state when RESTART_EN=1); valid stays high in DONE until ack or a
// new start is seen on an edge, start winning when both are high; ack has no
// effect outside DONE. All datapath outputs are decoded from registered state.
module div_seq_controller
    import div_pkg::*;
#(
    parameter int  WIDTH      = 8,
    parameter bit  RESTART_EN = 1'b1,
    localparam int CW         = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sign,
    input  logic          divisor_zero,
    input  logic          ack,
    output logic          load,
    output logic          add,
    output logic          shift,
    output logic          inbit,
    output logic [1:0]    sel,
    output logic          valid,
    output logic          busy,
    output logic          dbz,
    output logic [CW-1:0] iter_cnt,
    output logic [2:0]    o_state_dbg
);

    state_t        r_state;
    state_t        w_next;
    logic          r_dbz;
    logic          w_in_busy;
    logic          w_accept;
    logic          w_iter_end;
    logic          w_cnt_last;
    logic [CW-1:0] w_cnt;
    ctrl_t         w_ctrl;

    assign w_in_busy  = (r_state == S_LOAD) || (r_state == S_SUB) ||
                        (r_state == S_RESTORE) || (r_state == S_SHIFT1);
    assign w_iter_end = (r_state == S_RESTORE) || (r_state == S_SHIFT1);
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (RESTART_EN && w_in_busy));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an accepted start overrides every other transition
    always_comb begin
        w_next = r_state;
        if (w_accept) begin
            w_next = divisor_zero ? S_DONE : S_LOAD;
        end else begin
            case (r_state)
                S_IDLE:    w_next = S_IDLE;
                S_LOAD:    w_next = S_SUB;
                S_SUB:     w_next = sign ? S_RESTORE : S_SHIFT1;
                S_RESTORE: w_next = w_cnt_last ? S_DONE : S_SUB;
                S_SHIFT1:  w_next = w_cnt_last ? S_DONE : S_SUB;
                S_DONE:    w_next = ack ? S_IDLE : S_DONE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Divide-by-zero flag: captured with each accepted start, released by ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= divisor_zero;
        end else if ((r_state == S_DONE) && ack) begin
            r_dbz <= 1'b0;
        end
    end

    // Counter is cleared on every accepted start so LOAD already shows 0
    div_iter_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_accept),
        .i_inc   (w_iter_end),
        .o_cnt   (w_cnt),
        .o_last  (w_cnt_last)
    );

    // Moore output decode
    always_comb begin
        w_ctrl = decode_state(r_state);
    end

    assign load        = w_ctrl.load;
    assign add         = w_ctrl.add;
    assign shift       = w_ctrl.shift;
    assign inbit       = w_ctrl.inbit;
    assign sel         = w_ctrl.sel;
    assign valid       = w_ctrl.valid;
    assign busy        = w_ctrl.busy;
    assign dbz         = r_dbz;
    assign iter_cnt    = w_cnt;
    assign o_state_dbg = r_state;

endmodule

// File: tb/tb_div_seq_controller.sv
module tb_div_seq_controller;

  // control rows {load,add,shift,inbit,sel[1:0],valid,busy}
  localparam logic [7:0] ROW_IDLE    = 8'b0000_11_00;
  localparam logic [7:0] ROW_LOAD    = 8'b1010_10_01;
  localparam logic [7:0] ROW_SUB     = 8'b0000_01_01;
  localparam logic [7:0] ROW_RESTORE = 8'b0110_01_01;
  localparam logic [7:0] ROW_SHIFT1  = 8'b0011_11_01;
  localparam logic [7:0] ROW_DONE    = 8'b0000_11_10;
  localparam logic [13:0] M_ALL    = 14'h3fff;
  localparam logic [13:0] M_NO_CNT = 14'h20ff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  // per-DUT stimulus; dut0: W8 restart on, dut1: W8 restart off, dut2: W16
  logic   start_v [3];
  logic   dz_v    [3];
  logic   ack_v   [3];
  logic   sign_v  [3];
  longint dvd_v   [3];
  longint dvs_v   [3];
  longint rem_m   [3];
  longint dreg_m  [3];

  logic [7:0] ctl_v [3];
  logic       dbz_v [3];
  logic [4:0] cnt_v [3];

  wire [7:0] ctl0, ctl1, ctl2;
  wire       dbz0, dbz1, dbz2;
  wire [3:0] cnt0, cnt1;
  wire [4:0] cnt2;
  wire [2:0] st0, st1, st2;

  logic [13:0] exp_q[$];
  logic [13:0] msk_q[$];
  logic [13:0] obs_q[$];

  function automatic int wof(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  div_seq_controller #(.WIDTH(8), .RESTART_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .sign(sign_v[0]),
    .divisor_zero(dz_v[0]), .ack(ack_v[0]), .load(ctl0[7]), .add(ctl0[6]),
    .shift(ctl0[5]), .inbit(ctl0[4]), .sel(ctl0[3:2]), .valid(ctl0[1]),
    .busy(ctl0[0]), .dbz(dbz0), .iter_cnt(cnt0), .o_state_dbg(st0));

  div_seq_controller #(.WIDTH(8), .RESTART_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .sign(sign_v[1]),
    .divisor_zero(dz_v[1]), .ack(ack_v[1]), .load(ctl1[7]), .add(ctl1[6]),
    .shift(ctl1[5]), .inbit(ctl1[4]), .sel(ctl1[3:2]), .valid(ctl1[1]),
    .busy(ctl1[0]), .dbz(dbz1), .iter_cnt(cnt1), .o_state_dbg(st1));

  div_seq_controller #(.WIDTH(16), .RESTART_EN(1'b1)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .sign(sign_v[2]),
    .divisor_zero(dz_v[2]), .ack(ack_v[2]), .load(ctl2[7]), .add(ctl2[6]),
    .shift(ctl2[5]), .inbit(ctl2[4]), .sel(ctl2[3:2]), .valid(ctl2[1]),
    .busy(ctl2[0]), .dbz(dbz2), .iter_cnt(cnt2), .o_state_dbg(st2));

  assign ctl_v[0] = ctl0;
  assign ctl_v[1] = ctl1;
  assign ctl_v[2] = ctl2;
  assign dbz_v[0] = dbz0;
  assign dbz_v[1] = dbz1;
  assign dbz_v[2] = dbz2;
  assign cnt_v[0] = {1'b0, cnt0};
  assign cnt_v[1] = {1'b0, cnt1};
  assign cnt_v[2] = cnt2;

  // reference datapath: divisor register and an unbounded remainder register
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sign_v[i] = (((rem_m[i] >>> wof(i)) - dreg_m[i]) < 0);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        rem_m[i]  <= 0;
        dreg_m[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ctl_v[i][7]) begin
          dreg_m[i] <= dvs_v[i];
          rem_m[i]  <= dvd_v[i] << 1;
        end else if (ctl_v[i][3:2] == 2'b01) begin
          if (ctl_v[i][5])
            rem_m[i] <= ((ctl_v[i][6] ? rem_m[i] + (dreg_m[i] << wof(i))
                                      : rem_m[i] - (dreg_m[i] << wof(i))) << 1)
                        | longint'(ctl_v[i][4]);
          else
            rem_m[i] <= ctl_v[i][6] ? rem_m[i] + (dreg_m[i] << wof(i))
                                    : rem_m[i] - (dreg_m[i] << wof(i));
        end else if (ctl_v[i][5]) begin
          rem_m[i] <= (rem_m[i] << 1) | longint'(ctl_v[i][4]);
        end
      end
    end
  end

  function automatic logic [13:0] wd(input bit d, input int cnt, input logic [7:0] row);
    return {d, 5'(cnt), row};
  endfunction

  // ---------------- reference model ----------------
  // Expected per-cycle words from start acceptance onward, derived from a/b
  task automatic ref_seq(input int i, input longint a, input longint b);
    longint q;
    int w;
    w = wof(i);
    exp_q.delete();
    msk_q.delete();
    if (b == 0) begin
      exp_q.push_back(wd(1'b1, 0, ROW_DONE));
      msk_q.push_back(M_NO_CNT);
    end else begin
      q = a / b;
      exp_q.push_back(wd(1'b0, 0, ROW_LOAD));
      msk_q.push_back(M_ALL);
      for (int k = 0; k < w; k++) begin
        exp_q.push_back(wd(1'b0, k, ROW_SUB));
        msk_q.push_back(M_ALL);
        exp_q.push_back(wd(1'b0, k, ((q >> (w - 1 - k)) & 1) != 0 ? ROW_SHIFT1 : ROW_RESTORE));
        msk_q.push_back(M_ALL);
      end
      exp_q.push_back(wd(1'b0, w, ROW_DONE));
      msk_q.push_back(M_ALL);
    end
  endtask

  // ---------------- driver ----------------
  // Raise start right after an edge, then record one word per cycle
  task automatic run_op(input int i, input longint a, input longint b, input int max_c,
                        input int inject_c, input bit with_ack, output int lat);
    bit got;
    dvd_v[i] = a;
    dvs_v[i] = b;
    dz_v[i]  = (b == 0);
    obs_q.delete();
    @(posedge clk);
    #1;
    start_v[i] = 1'b1;
    ack_v[i]   = with_ack;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= max_c && !got; c++) begin
      @(posedge clk);
      #1;
      start_v[i] = (c == inject_c);
      ack_v[i]   = 1'b0;
      @(negedge clk);
      obs_q.push_back({dbz_v[i], cnt_v[i], ctl_v[i]});
      if (ctl_v[i][1]) begin
        got = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic pulse_ack(input int i);
    @(posedge clk);
    #1;
    ack_v[i] = 1'b1;
    @(posedge clk);
    #1;
    ack_v[i] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [13:0] obs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      obs = {dbz_v[i], cnt_v[i], ctl_v[i]};
      nvec++;
      if (obs !== wd(1'b0, 0, ROW_IDLE)) begin
        nfail++;
        $display("FAIL reset_dut%0d got %h want %h", i, obs, wd(1'b0, 0, ROW_IDLE));
      end
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      obs = {dbz_v[i], cnt_v[i], ctl_v[i]};
      nvec++;
      if (obs !== wd(1'b0, 0, ROW_IDLE)) begin
        nfail++;
        $display("FAIL idle_after_reset_dut%0d got %h want %h", i, obs, wd(1'b0, 0, ROW_IDLE));
      end
    end
  endtask

  task automatic test_divide(input string name, input int i, input longint a, input longint b,
                             input bit with_ack);
    int lat;
    int w;
    longint q;
    longint r;
    w = wof(i);
    ref_seq(i, a, b);
    run_op(i, a, b, 4 * w + 10, 0, with_ack, lat);
    for (int k = 0; k < exp_q.size(); k++) begin
      nvec++;
      if (k >= obs_q.size() || (obs_q[k] & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        nfail++;
        $display("FAIL %s_seq cyc%0d got %h want %h", name, k + 1,
                 (k < obs_q.size()) ? obs_q[k] : 14'h0, exp_q[k]);
      end
    end
    nvec++;
    if (lat !== ((b == 0) ? 1 : 2 + 2 * w)) begin
      nfail++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, (b == 0) ? 1 : 2 + 2 * w);
    end
    if (b != 0) begin
      q = rem_m[i] & ((longint'(1) << w) - 1);
      r = (rem_m[i] >>> w) >> 1;
      nvec++;
      if (q !== a / b || r !== a % b) begin
        nfail++;
        $display("FAIL %s_result got q=%0d r=%0d want q=%0d r=%0d", name, q, r, a / b, a % b);
      end
    end
  endtask

  task automatic test_ack_release(input string name, input int i);
    logic [8:0] obs;
    pulse_ack(i);
    obs = {dbz_v[i], ctl_v[i]};
    nvec++;
    if (obs !== {1'b0, ROW_IDLE}) begin
      nfail++;
      $display("FAIL %s_ack got %h want %h", name, obs, {1'b0, ROW_IDLE});
    end
  endtask

  task automatic test_done_hold();
    logic [13:0] obs;
    test_divide("hold_run", 0, 100, 7, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      obs = {dbz_v[0], cnt_v[0], ctl_v[0]};
      nvec++;
      if (obs !== wd(1'b0, 8, ROW_DONE)) begin
        nfail++;
        $display("FAIL done_hold cyc%0d got %h want %h", c, obs, wd(1'b0, 8, ROW_DONE));
      end
    end
    // ack and start together: start wins, a fresh run begins
    test_divide("ack_start", 0, 200, 9, 1'b1);
  endtask

  task automatic test_dbz();
    logic [13:0] obs;
    test_divide("dbz", 0, 55, 0, 1'b0);
    repeat (2) @(negedge clk);
    obs = {dbz_v[0], cnt_v[0], ctl_v[0]};
    nvec++;
    if ((obs & M_NO_CNT) !== wd(1'b1, 0, ROW_DONE)) begin
      nfail++;
      $display("FAIL dbz_hold got %h want %h", obs, wd(1'b1, 0, ROW_DONE));
    end
    test_ack_release("dbz", 0);
  endtask

  task automatic test_restart();
    int lat;
    // dut0: abort after iteration-5 SUB, restart with new operands
    ref_seq(0, 250, 13);
    run_op(0, 250, 13, 12, 0, 1'b0, lat);
    for (int k = 0; k < obs_q.size(); k++) begin
      nvec++;
      if (obs_q[k] !== exp_q[k]) begin
        nfail++;
        $display("FAIL restart_prefix cyc%0d got %h want %h", k + 1, obs_q[k], exp_q[k]);
      end
    end
    nvec++;
    if (obs_q.size() !== 12 || cnt_v[0] !== 5'd5) begin
      nfail++;
      $display("FAIL restart_point got n=%0d cnt=%0d want n=12 cnt=5", obs_q.size(), cnt_v[0]);
    end
    test_divide("restart_on", 0, 77, 5, 1'b0);
    // dut1: the same start pulse mid-run is ignored, original run completes
    ref_seq(1, 250, 13);
    run_op(1, 250, 13, 60, 12, 1'b0, lat);
    for (int k = 0; k < exp_q.size(); k++) begin
      nvec++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        nfail++;
        $display("FAIL restart_off_seq cyc%0d got %h want %h", k + 1,
                 (k < obs_q.size()) ? obs_q[k] : 14'h0, exp_q[k]);
      end
    end
    nvec++;
    if (lat !== 18 || (rem_m[1] & 255) !== 250 / 13) begin
      nfail++;
      $display("FAIL restart_off_result got lat=%0d q=%0d want lat=18 q=%0d",
               lat, rem_m[1] & 255, 250 / 13);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [13:0] obs;
    run_op(0, 123, 11, 6, 0, 1'b0, lat);
    nvec++;
    if (ctl_v[0] !== ROW_SUB) begin
      nfail++;
      $display("FAIL areset_setup got %h want %h", ctl_v[0], ROW_SUB);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {dbz_v[0], cnt_v[0], ctl_v[0]};
    nvec++;
    if (obs !== wd(1'b0, 0, ROW_IDLE)) begin
      nfail++;
      $display("FAIL areset_immediate got %h want %h", obs, wd(1'b0, 0, ROW_IDLE));
    end
    @(negedge clk);
    reset = 1'b0;
    test_divide("after_reset", 0, 123, 11, 1'b0);
  endtask

  task automatic test_random();
    int i;
    int w;
    longint a;
    longint b;
    for (int n = 0; n < 12; n++) begin
      i = $urandom_range(0, 2);
      w = wof(i);
      a = longint'($urandom_range(0, (1 << w) - 1));
      b = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(1, (1 << w) - 1));
      test_divide("random", i, a, b, 1'b0);
      if ($urandom_range(0, 1) == 1) test_ack_release("random", i);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      ack_v[i]   = 1'b0;
      dz_v[i]    = 1'b0;
      dvd_v[i]   = 0;
      dvs_v[i]   = 1;
    end
    test_reset();
    test_divide("basic", 0, 100, 7, 1'b0);
    test_ack_release("basic", 0);
    test_dbz();
    test_done_hold();
    test_restart();
    test_async_reset();
    test_divide("w16", 2, 16'hffff, 3, 1'b0);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
